// File: rtl/afu_pkg.sv
// Shared AFU definitions: a trimmed set of CCI-P c1 channel types, the write
// engine state encoding and the MMIO register map that drives the engine.
package afu_pkg;

  localparam int WR_MAX_OUTSTANDING = 64;

  localparam logic [15:0] MMIO_WR_BASE_ADDR = 16'h000A;
  localparam logic [15:0] MMIO_WR_NUM_LINES = 16'h000C;
  localparam logic [15:0] MMIO_WR_SEED      = 16'h000E;
  localparam logic [15:0] MMIO_WR_STATUS    = 16'h0010;
  localparam logic [15:0] MMIO_WR_COUNTS    = 16'h0012;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [15:0]  t_ccip_mdata;

  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4, eREQ_INTR     = 4'h6
  } t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h1, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} t_wr_state;

  function automatic logic [63:0] lineWord(input logic [63:0] seed, input logic [15:0] idx);
    return seed + {48'h0, idx};
  endfunction

  // A packed response acknowledges cl_num+1 lines at once.
  function automatic logic [2:0] rspLines(input logic format, input logic [1:0] clNum);
    return format ? ({1'b0, clNum} + 3'd1) : 3'd1;
  endfunction

endpackage

// File: rtl/ccip_wr_engine_if.sv
// CCI-P c1 write channel bundle between the write engine and the platform shim.
interface ccip_wr_engine_if;
  import afu_pkg::*;

  t_if_ccip_c1_Tx c1_tx;
  logic           c1_tx_alm_full;
  t_if_ccip_c1_Rx c1_rx;

  modport master (output c1_tx, input c1_tx_alm_full, input c1_rx);
  modport slave  (input c1_tx, output c1_tx_alm_full, output c1_rx);

endinterface

// File: rtl/ccip_wr_rsp_counter.sv
// Decodes c1 Rx write responses, accumulates acknowledged lines for the
// current job and flags responses that the engine never asked for.
module ccip_wr_rsp_counter
  import afu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  t_if_ccip_c1_Rx c1_rx_i,
  input  logic [15:0]    lines_issued_i,
  output logic [15:0]    lines_acked_o,
  output logic           err_o
);

  logic [15:0] acked_q, acked_d;
  logic        err_q, err_d;
  logic        rspHit;
  logic [15:0] outstanding;
  logic [15:0] rspCount;
  logic        unusedRspBits;

  assign rspHit      = c1_rx_i.rspValid && (c1_rx_i.hdr.resp_type == eRSP_WRLINE);
  assign outstanding = lines_issued_i - acked_q;
  assign rspCount    = {13'h0, rspLines(c1_rx_i.hdr.format, c1_rx_i.hdr.cl_num)};
  assign unusedRspBits = ^{c1_rx_i.hdr.vc_used, c1_rx_i.hdr.hit_miss, c1_rx_i.hdr.mdata};

  // Over-acknowledgement (including any ack with nothing outstanding) pins
  // the count at the issued total so outstanding never goes negative.
  always_comb begin
    acked_d = acked_q;
    err_d   = err_q;
    if (clear_i) begin
      acked_d = '0;
      err_d   = 1'b0;
    end else if (rspHit) begin
      if (rspCount > outstanding) begin
        acked_d = lines_issued_i;
        err_d   = 1'b1;
      end else begin
        acked_d = acked_q + rspCount;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acked_q <= '0;
      err_q   <= 1'b0;
    end else begin
      acked_q <= acked_d;
      err_q   <= err_d;
    end
  end

  assign lines_acked_o = acked_q;
  assign err_o         = err_q;

endmodule

// File: rtl/ccip_wr_engine.sv
// Multi-line CCI-P write engine: streams num_lines seeded 64-byte writes onto
// c1 Tx under almost-full and outstanding-request limits, then waits for acks.
module ccip_wr_engine
  import afu_pkg::*;
#(
  parameter int       MAX_OUTSTANDING = WR_MAX_OUTSTANDING,
  parameter t_ccip_vc VC_SEL          = eVC_VA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  t_ccip_clAddr            base_addr_i,
  input  logic [15:0]             num_lines_i,
  input  logic [63:0]             seed_i,
  ccip_wr_engine_if.master        ccip,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [15:0]             lines_issued_o,
  output logic [15:0]             lines_acked_o
);

  localparam logic [15:0] MaxOut = 16'(MAX_OUTSTANDING);

  t_wr_state      state_q, state_d;
  t_ccip_clAddr   baseAddr_q, baseAddr_d;
  logic [15:0]    numLines_q, numLines_d;
  logic [63:0]    seed_q, seed_d;
  logic [15:0]    issued_q, issued_d;
  logic           done_q, done_d;
  t_if_ccip_c1_Tx tx_q, tx_d;
  logic [15:0]    acked;
  logic           rspErr;
  logic           startAccept;
  logic           canIssue;

  assign startAccept = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign canIssue    = (state_q == ISSUE) && !ccip.c1_tx_alm_full
                       && ((issued_q - acked) < MaxOut);

  ccip_wr_rsp_counter uRspCounter (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (startAccept),
    .c1_rx_i        (ccip.c1_rx),
    .lines_issued_i (issued_q),
    .lines_acked_o  (acked),
    .err_o          (rspErr)
  );

  // Request payload is built from the pre-increment counter and registered,
  // so the header seen on c1 Tx always names the line that was just counted.
  always_comb begin
    state_d    = state_q;
    baseAddr_d = baseAddr_q;
    numLines_d = numLines_q;
    seed_d     = seed_q;
    issued_d   = issued_q;
    done_d     = done_q;
    tx_d       = tx_q;
    tx_d.valid = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (startAccept) begin
          baseAddr_d = base_addr_i;
          numLines_d = num_lines_i;
          seed_d     = seed_i;
          issued_d   = '0;
          done_d     = (num_lines_i == 16'h0);
          state_d    = (num_lines_i == 16'h0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (canIssue) begin
          tx_d.valid        = 1'b1;
          tx_d.hdr.vc_sel   = VC_SEL;
          tx_d.hdr.sop      = 1'b1;
          tx_d.hdr.cl_len   = eCL_LEN_1;
          tx_d.hdr.req_type = eREQ_WRLINE_I;
          tx_d.hdr.address  = baseAddr_q + t_ccip_clAddr'(issued_q);
          tx_d.hdr.mdata    = issued_q;
          tx_d.data         = {8{lineWord(seed_q, issued_q)}};
          issued_d          = issued_q + 16'd1;
          if ((issued_q + 16'd1) == numLines_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (acked == issued_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baseAddr_q <= '0;
      numLines_q <= '0;
      seed_q     <= '0;
      issued_q   <= '0;
      done_q     <= 1'b0;
      tx_q       <= '0;
    end else begin
      state_q    <= state_d;
      baseAddr_q <= baseAddr_d;
      numLines_q <= numLines_d;
      seed_q     <= seed_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
    end
  end

  assign ccip.c1_tx     = tx_q;
  assign busy_o         = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o         = done_q;
  assign err_o          = rspErr;
  assign lines_issued_o = issued_q;
  assign lines_acked_o  = acked;

endmodule

// File: tb/tb_ccip_wr_engine.sv
// Scoreboard bench for ccip_wr_engine: each job predicts its write requests as
// a line list; a monitor pops and compares whatever appears on c1 Tx.
module tb_ccip_wr_engine;
  import afu_pkg::*;

  localparam int MaxOut = 4;

  typedef struct {
    t_ccip_clAddr addr;
    logic [15:0]  mdata;
    logic [63:0]  word;
  } expReq_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  t_ccip_clAddr baseAddr = '0;
  logic [15:0]  numLines = '0;
  logic [63:0]  seed = '0;
  logic         busy, done, err;
  logic [15:0]  linesIssued, linesAcked;

  int checks = 0;
  int errors = 0;
  expReq_t        expQ[$];
  t_if_ccip_c1_Rx rspCmdQ[$];
  int  seenCount = 0;
  int  pendingLines = 0;
  int  autoMode = 0;
  bit  afForce = 1'b0;
  bit  afRandom = 1'b0;
  bit  afPrev = 1'b0;

  ccip_wr_engine_if ccip();

  ccip_wr_engine #(.MAX_OUTSTANDING(MaxOut), .VC_SEL(eVC_VA)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .base_addr_i    (baseAddr),
    .num_lines_i    (numLines),
    .seed_i         (seed),
    .ccip           (ccip.master),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .lines_issued_o (linesIssued),
    .lines_acked_o  (linesAcked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkWide(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic t_if_ccip_c1_Rx mkRsp(input t_ccip_c1_rsp t, input logic fmt, input logic [1:0] cl);
    t_if_ccip_c1_Rx r = '0;
    r.rspValid      = 1'b1;
    r.hdr.resp_type = t;
    r.hdr.format    = fmt;
    r.hdr.cl_num    = cl;
    return r;
  endfunction

  task automatic pulseStart(input t_ccip_clAddr b, input logic [15:0] n, input logic [63:0] s);
    @(posedge clk); #1;
    start = 1'b1; baseAddr = b; numLines = n; seed = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference model: line i of a job goes to base+i (42-bit wrap) carrying seed+i.
  task automatic applyStimulus(input t_ccip_clAddr b, input int n, input logic [63:0] s);
    for (int i = 0; i < n; i++) begin
      expReq_t e;
      e.addr  = b + 42'(i);
      e.mdata = 16'(i);
      e.word  = s + 64'(i);
      expQ.push_back(e);
    end
    seenCount = 0;
    pulseStart(b, 16'(n), s);
  endtask

  task automatic waitDone(input int n, input string tag);
    int cyc = 0;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_timeout: done=0 after %0d cycles, expected 1", tag, cyc);
    end
    @(negedge clk);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_acked"}, 64'(linesAcked), 64'(n));
    checkOutput({tag, "_issued"}, 64'(linesIssued), 64'(n));
    checkOutput({tag, "_seen"}, 64'(seenCount), 64'(n));
    checkOutput({tag, "_expq_left"}, 64'(expQ.size()), 64'd0);
  endtask

  initial begin : monitor
    expReq_t            e;
    t_ccip_c1_ReqMemHdr expHdr;
    forever begin
      @(negedge clk);
      if (!rst && ccip.c1_tx.valid) begin
        seenCount++;
        pendingLines++;
        checkOutput("almfull_gate", 64'(afPrev), 64'd0);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_req: got request addr=0x%0h, expected none", ccip.c1_tx.hdr.address);
        end else begin
          e = expQ.pop_front();
          expHdr.vc_sel   = eVC_VA;
          expHdr.sop      = 1'b1;
          expHdr.cl_len   = eCL_LEN_1;
          expHdr.req_type = eREQ_WRLINE_I;
          expHdr.address  = e.addr;
          expHdr.mdata    = e.mdata;
          checkWide("req_hdr", 512'(ccip.c1_tx.hdr), 512'(expHdr));
          checkWide("req_data", ccip.c1_tx.data, {8{e.word}});
        end
      end
      afPrev = ccip.c1_tx_alm_full;
    end
  end

  // Mode 1 acks one line per cycle; mode 2 acks random packed groups and
  // sprinkles in unrelated response types that must be ignored.
  initial begin : responder
    t_if_ccip_c1_Rx r;
    int k;
    ccip.c1_rx = '0;
    forever begin
      @(posedge clk); #1;
      r = '0;
      if (rspCmdQ.size() > 0) begin
        r = rspCmdQ.pop_front();
      end else if (autoMode == 1 && pendingLines > 0) begin
        r = mkRsp(eRSP_WRLINE, 1'b0, 2'd0);
        pendingLines--;
      end else if (autoMode == 2 && pendingLines > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(1, 4);
        if (k > pendingLines) k = pendingLines;
        r = mkRsp(eRSP_WRLINE, (k > 1) ? 1'b1 : 1'($urandom_range(0, 1)), 2'(k - 1));
        pendingLines -= k;
      end else if (autoMode == 2 && $urandom_range(0, 7) == 0) begin
        r = mkRsp(eRSP_INTR, 1'b1, 2'd3);
      end
      ccip.c1_rx = r;
    end
  end

  initial begin : almFullDriver
    ccip.c1_tx_alm_full = 1'b0;
    forever begin
      @(posedge clk); #2;
      ccip.c1_tx_alm_full = afForce | (afRandom & ($urandom_range(0, 3) == 0));
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainFlow
    int cyc;
    t_ccip_clAddr b;
    int n;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(ccip.c1_tx.valid), 64'd0);
    checkOutput("rst_hdr_addr", 64'(ccip.c1_tx.hdr.address), 64'd0);
    checkOutput("rst_data_lo", ccip.c1_tx.data[63:0], 64'd0);
    checkOutput("rst_status", 64'({err, done, busy}), 64'd0);
    checkOutput("rst_counts", 64'({linesAcked, linesIssued}), 64'd0);
    @(negedge clk) rst = 1'b0;

    $display("[TB] basic 4-line job");
    autoMode = 1;
    applyStimulus(42'h1000, 4, 64'h0021646c726f7720);
    waitDone(4, "basic");

    $display("[TB] zero-line job");
    applyStimulus(42'h2000, 0, 64'h5);
    checkOutput("zero_done_next", 64'(done), 64'd1);
    checkOutput("zero_busy_next", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("zero_busy_later", 64'(busy), 64'd0);
    checkOutput("zero_seen", 64'(seenCount), 64'd0);
    checkOutput("zero_issued", 64'(linesIssued), 64'd0);

    $display("[TB] almost-full window");
    applyStimulus(42'h3000, 8, {$urandom, $urandom});
    @(posedge clk); #1;
    afForce = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("af_stall_seen", 64'(seenCount), 64'd1);
    afForce = 1'b0;
    waitDone(8, "almfull");

    $display("[TB] outstanding limit");
    autoMode = 0;
    applyStimulus(42'h4000, 10, 64'h1111_2222_3333_4444);
    repeat (12) @(negedge clk);
    checkOutput("maxout_stall_seen", 64'(seenCount), 64'd4);
    checkOutput("maxout_stall_issued", 64'(linesIssued), 64'd4);
    pulseStart(42'h7777, 16'd3, 64'hdead);
    rspCmdQ.push_back(mkRsp(eRSP_WRLINE, 1'b1, 2'd3));
    pendingLines -= 4;
    repeat (12) @(negedge clk);
    checkOutput("maxout_packed_acked", 64'(linesAcked), 64'd4);
    checkOutput("maxout_second_seen", 64'(seenCount), 64'd8);
    checkOutput("maxout_busy", 64'(busy), 64'd1);
    autoMode = 1;
    waitDone(10, "maxout");

    $display("[TB] spurious responses while idle");
    autoMode = 0;
    rspCmdQ.push_back(mkRsp(eRSP_WRFENCE, 1'b0, 2'd0));
    repeat (3) @(negedge clk);
    checkOutput("fence_err", 64'(err), 64'd0);
    checkOutput("fence_acked", 64'(linesAcked), 64'd10);
    rspCmdQ.push_back(mkRsp(eRSP_WRLINE, 1'b0, 2'd0));
    repeat (3) @(negedge clk);
    checkOutput("spurious_err", 64'(err), 64'd1);
    checkOutput("spurious_counts", 64'({linesAcked, linesIssued}), 64'({16'd10, 16'd10}));
    checkOutput("spurious_done", 64'(done), 64'd1);

    $display("[TB] random jobs");
    autoMode = 2;
    afRandom = 1'b1;
    for (int j = 0; j < 6; j++) begin
      b = (j == 0) ? 42'h3FF_FFFF_FFFE : 42'({$urandom, $urandom});
      n = (j == 0) ? 5 : $urandom_range(1, 20);
      applyStimulus(b, n, {$urandom, $urandom});
      if (j == 0) checkOutput("start_clears_err", 64'(err), 64'd0);
      waitDone(n, "rand");
    end
    afRandom = 1'b0;

    $display("[TB] reset during issue");
    autoMode = 0;
    applyStimulus(42'h5000, 8, 64'h0123_4567_89ab_cdef);
    cyc = 0;
    while (seenCount < 3 && cyc < 50) begin
      @(posedge clk); #2;
      cyc++;
    end
    checkOutput("rst_mid_reached", 64'(seenCount), 64'd3);
    rst = 1'b1;
    #1;
    expQ.delete();
    rspCmdQ.delete();
    pendingLines = 0;
    checkOutput("rst_mid_valid", 64'(ccip.c1_tx.valid), 64'd0);
    checkOutput("rst_mid_status", 64'({err, done, busy}), 64'd0);
    checkOutput("rst_mid_counts", 64'({linesAcked, linesIssued}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    autoMode = 1;
    applyStimulus(42'h6000, 8, 64'hfeed_face_cafe_beef);
    waitDone(8, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_wr_engine.md
Name: ccip_wr_engine

Overview:
- Multi-line CCI-P write engine that sits directly downstream of the AFU MMIO register decode.
- When the MMIO block pulses start with a buffer address, line count and data seed, the engine streams that many 64-byte write requests onto c1 Tx, honouring almost-full backpressure.
- It counts write responses on c1 Rx and reports busy/done/error status back to the MMIO block for readback.
- It replaces the single hard-wired "write one line" path.

Parameters:
- MAX_OUTSTANDING, 64, maximum write requests in flight (issued minus acked); must be ≤ 512.
- VC_SEL, eVC_VA, virtual channel placed in every request header.

Ports:
- clk  in  1  CCI-P clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse from MMIO decode; captures base_addr/num_lines/seed
- base_addr  in  t_ccip_clAddr (42)  cache-line address of line 0
- num_lines  in  16  lines to write; 0 is legal
- seed  in  64  data seed
- c1_tx  out  t_if_ccip_c1_Tx  write request channel (hdr, data, valid)
- c1_tx_alm_full  in  1  c1TxAlmFull from platform
- c1_rx  in  t_if_ccip_c1_Rx  write response channel (hdr, rspValid)
- busy  out  1  high from cycle after accepted start until done
- done  out  1  sticky; set when all lines acked, cleared by next accepted start
- err  out  1  sticky; response received with zero outstanding; cleared by accepted start
- lines_issued  out  16  requests issued in current job
- lines_acked  out  16  lines acknowledged in current job

Behaviour:
- Reset (async, any state): state=IDLE; c1_tx.valid=0, c1_tx.hdr=0, c1_tx.data=0; busy=0, done=0, err=0, counters=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start: latch inputs; clear counters, done, err.
  - Go to ISSUE if num_lines≠0.
  - If num_lines=0, go to DONE with done=1 one cycle after start; no requests are issued.
- start while busy is ignored entirely; latched values are unchanged.
- ISSUE: one request per cycle when c1_tx_alm_full=0 AND outstanding<MAX_OUTSTANDING. Otherwise c1_tx.valid=0 that cycle.
  - Request fields:
    - eREQ_WRLINE_I, eCL_LEN_1, sop=1, VC_SEL
    - address = base_addr + lines_issued, modulo 2^42 wrap
    - mdata = lines_issued
    - data = 8 copies of (seed + lines_issued), 64-bit modulo add, word 0 in bits [63:0]
  - c1_tx is registered: request fields are computed from the counter and valid asserted on the next edge. Outputs hold only while valid=1.
  - After the request for line num_lines-1 is issued, go to DRAIN.
- Response counting (all states): c1_rx.rspValid with hdr.resp_type=eRSP_WRLINE.
  - format=0: adds 1.
  - format=1 (packed): adds cl_num+1.
  - Other response types are ignored.
- outstanding = lines_issued - lines_acked (16-bit). An issue and a response in the same cycle update both counters correctly.
- err: set if a response arrives while outstanding=0, or would make lines_acked exceed lines_issued. lines_acked saturates at lines_issued.
- DRAIN: when lines_acked == lines_issued, go to DONE, assert done=1, drop busy. DONE is indistinguishable from IDLE apart from done.
- busy = (state==ISSUE || state==DRAIN).
- Latency: start at edge N gives the first c1_tx.valid at edge N+2 if not backpressured.
- alm_full only gates new issues; it never drops or repeats a request.

Decomposition:
- Shared package afu_pkg:
  - state enum t_wr_state
  - MMIO offsets for the engine registers: 0x000A base address (write triggers start), 0x000C num_lines, 0x000E seed, 0x0010 status {err, done, busy}, 0x0012 {lines_acked, lines_issued}
  - default MAX_OUTSTANDING
- One natural sub-module: ccip_wr_rsp_counter. It decodes c1_rx, accumulates lines_acked, and flags err. It keeps the packed-response arithmetic isolated for unit test.

Test Plan:
- start, base=0x1000, num_lines=4, seed=0x0021646c726f7720, no backpressure, immediate single acks:
  - 4 requests at addr 0x1000..0x1003, mdata 0..3
  - line 2 data words = seed+2
  - done=1, busy=0, acked=4, err=0
- num_lines=0 -> no c1_tx.valid ever; done=1 one cycle after start; busy stays 0.
- num_lines=8, alm_full held high for cycles 2–5 of ISSUE:
  - no valid during those cycles
  - all 8 addresses issued exactly once, in order, no gaps or repeats
- MAX_OUTSTANDING=4, num_lines=10, responses withheld:
  - issue stalls at issued=4
  - one packed response (format=1, cl_num=3) -> acked=4 and 4 more issue
  - all acked -> done=1
- Spurious eRSP_WRLINE in IDLE -> err=1, counters unchanged; next start clears err.
- Reset asserted mid-ISSUE after 3 of 8 lines -> c1_tx.valid=0 immediately; all status=0; a new start runs a full job correctly.
